rgbled_frame_scaler: RTL and testbench

Global-brightness stage between the SPI frame receiver and the RGB LED serial driver.
- Captures each completed SPI frame, on the rising edge of the receiver's ready flag.
- Scales every 8-bit colour channel by a global brightness value, using a sequential shift-add multiplier.
- Presents the scaled frame to the LED driver with a one-cycle ready pulse.
- Fully in the clk domain; the receiver's ready flag is treated as asynchronous.

---
 rtl/rgbled_pkg.sv | 22 ++
 rtl/rgbled_frame_scaler_if.sv | 26 ++
 rtl/rgbled_sync_edge.sv | 27 ++
 rtl/rgbled_frame_scaler.sv | 165 ++++++++++++++++
 tb/tb_rgbled_frame_scaler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rgbled_pkg.sv
// Shared definitions for the RGB LED frame scaler: FSM states, default channel
// width and the gamma-2.2 table generator used when RGBLED_SCALER_GAMMA_EN is defined.
package rgbled_pkg;

    localparam int CH_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GAMMA = 3'd1,
        MUL   = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Only ever evaluated at elaboration time to fill a constant table.
    function automatic logic [7:0] gamma22(input int i);
        real x;
        x = 255.0 * ((real'(i) / 255.0) ** 2.2);
        return 8'($rtoi(x + 0.5));
    endfunction

endpackage

// File: rtl/rgbled_frame_scaler_if.sv
// Frame-in / frame-out bundle between the SPI receiver, the scaler and the LED driver.
interface rgbled_frame_scaler_if #(
    parameter int LEDS         = 3,
    parameter int BITS_PER_LED = 24,
    parameter int CH_BITS      = 8
);
    localparam int FRAME_W = LEDS * BITS_PER_LED;

    logic [FRAME_W-1:0] in_data;
    logic               in_rdy;
    logic [CH_BITS-1:0] brightness;
    logic [FRAME_W-1:0] out_data;
    logic               out_rdy;
    logic               busy;

    modport master (
        output in_data, in_rdy, brightness,
        input  out_data, out_rdy, busy
    );

    modport slave (
        input  in_data, in_rdy, brightness,
        output out_data, out_rdy, busy
    );

endinterface

// File: rtl/rgbled_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for an asynchronous flag.
module rgbled_sync_edge (
    input  logic clk,
    input  logic nreset,
    input  logic async_in,
    output logic rise
);

    logic ff1_reg;
    logic ff2_reg;
    logic ff3_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ff1_reg <= 1'b0;
            ff2_reg <= 1'b0;
            ff3_reg <= 1'b0;
        end else begin
            ff1_reg <= async_in;
            ff2_reg <= ff1_reg;
            ff3_reg <= ff2_reg;
        end
    end

    assign rise = ff2_reg & ~ff3_reg;

endmodule

// File: rtl/rgbled_frame_scaler.sv
// Global-brightness scaler: captures a frame on in_rdy, scales each channel by
// (brightness+1)/256 with a shift-add multiplier. Optional: RGBLED_SCALER_GAMMA_EN.
module rgbled_frame_scaler
    import rgbled_pkg::*;
#(
    parameter int LEDS         = 3,
    parameter int BITS_PER_LED = 24,
    parameter int CH_BITS      = CH_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  nreset,
    rgbled_frame_scaler_if.slave  bus
);

    localparam int FRAME_W = LEDS * BITS_PER_LED;
    localparam int NCH     = FRAME_W / CH_BITS;
    localparam int ACC_W   = 2 * CH_BITS + 1;
    localparam int K_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W   = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;

`ifdef RGBLED_SCALER_GAMMA_EN
    localparam state_t CH_ENTRY = GAMMA;
`else
    localparam state_t CH_ENTRY = MUL;
`endif

    state_t             state_reg;
    logic [K_W-1:0]     k_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic [FRAME_W-1:0] work_reg;
    logic [CH_BITS-1:0] bright_reg;
    logic [CH_BITS-1:0] b_sh_reg;
    logic [ACC_W-1:0]   m_sh_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               pending_reg;
    logic [FRAME_W-1:0] out_data_reg;
    logic               out_rdy_reg;
    logic               busy_reg;

    logic               rise;
    logic               start_frame;
    logic [K_W-1:0]     k_next;
    logic [CH_BITS-1:0] result;
    logic               acc_unused;
    logic [CH_BITS-1:0] in_ch    [NCH];
    logic [CH_BITS-1:0] frame_ch [NCH];
    logic [FRAME_W-1:0] work_next;

    rgbled_sync_edge u_sync (
        .clk      (clk),
        .nreset   (nreset),
        .async_in (bus.in_rdy),
        .rise     (rise)
    );

    // Accumulator starts at c, so the top bit can never be reached.
    assign result     = acc_reg[2*CH_BITS-1:CH_BITS];
    assign acc_unused = acc_reg[ACC_W-1];
    assign k_next     = k_reg + K_W'(1);

    // A new frame starts from IDLE on an edge, or straight out of DONE if one was queued.
    assign start_frame = ((state_reg == IDLE) && rise) ||
                         ((state_reg == DONE) && (pending_reg || rise));

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign in_ch[gi]    = bus.in_data[gi*CH_BITS +: CH_BITS];
            assign frame_ch[gi] = frame_reg[gi*CH_BITS +: CH_BITS];
            assign work_next[gi*CH_BITS +: CH_BITS] =
                (k_reg == K_W'(gi)) ? result : work_reg[gi*CH_BITS +: CH_BITS];
        end
    endgenerate

`ifdef RGBLED_SCALER_GAMMA_EN
    logic [7:0] gamma_lut [256];
    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_gamma
            localparam logic [7:0] G_VAL = gamma22(gi);
            assign gamma_lut[gi] = G_VAL;
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg    <= IDLE;
            k_reg        <= '0;
            cnt_reg      <= '0;
            frame_reg    <= '0;
            work_reg     <= '0;
            bright_reg   <= '0;
            b_sh_reg     <= '0;
            m_sh_reg     <= '0;
            acc_reg      <= '0;
            pending_reg  <= 1'b0;
            out_data_reg <= '0;
            out_rdy_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            out_rdy_reg <= 1'b0;
            if (rise && (state_reg != IDLE))
                pending_reg <= 1'b1;

            case (state_reg)
                IDLE: ;
`ifdef RGBLED_SCALER_GAMMA_EN
                GAMMA: begin
                    acc_reg   <= ACC_W'(gamma_lut[frame_ch[k_reg]]);
                    m_sh_reg  <= ACC_W'(gamma_lut[frame_ch[k_reg]]);
                    state_reg <= MUL;
                end
`endif
                MUL: begin
                    if (b_sh_reg[0])
                        acc_reg <= acc_reg + m_sh_reg;
                    m_sh_reg <= m_sh_reg << 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(CH_BITS - 1))
                        state_reg <= STORE;
                end
                STORE: begin
                    work_reg <= work_next;
                    if (k_reg == K_W'(NCH - 1)) begin
                        out_data_reg <= work_next;
                        out_rdy_reg  <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        k_reg     <= k_next;
                        acc_reg   <= ACC_W'(frame_ch[k_next]);
                        m_sh_reg  <= ACC_W'(frame_ch[k_next]);
                        b_sh_reg  <= bright_reg;
                        cnt_reg   <= '0;
                        state_reg <= CH_ENTRY;
                    end
                end
                DONE: begin
                    busy_reg    <= 1'b0;
                    pending_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            if (start_frame) begin
                frame_reg   <= bus.in_data;
                bright_reg  <= bus.brightness;
                b_sh_reg    <= bus.brightness;
                acc_reg     <= ACC_W'(in_ch[0]);
                m_sh_reg    <= ACC_W'(in_ch[0]);
                k_reg       <= '0;
                cnt_reg     <= '0;
                busy_reg    <= 1'b1;
                pending_reg <= 1'b0;
                state_reg   <= CH_ENTRY;
            end
        end
    end

    assign bus.out_data = out_data_reg;
    assign bus.out_rdy  = out_rdy_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_rgbled_frame_scaler.sv
// Randomised self-checking bench for rgbled_frame_scaler against an arithmetic
// reference model; follows RGBLED_SCALER_GAMMA_EN when it is defined.
module tb_rgbled_frame_scaler;

    localparam int LEDS    = 3;
    localparam int BPL     = 24;
    localparam int CHB     = 8;
    localparam int FW      = LEDS * BPL;
    localparam int NCH     = FW / CHB;
`ifdef RGBLED_SCALER_GAMMA_EN
    localparam int EXP_LAT = 3 + NCH * (CHB + 2);
`else
    localparam int EXP_LAT = 3 + NCH * (CHB + 1);
`endif

    logic clk;
    logic nreset;
    int   errors;
    int   checks;
    int   frame_no;

    rgbled_frame_scaler_if #(.LEDS(LEDS), .BITS_PER_LED(BPL), .CH_BITS(CHB)) bus ();

    rgbled_frame_scaler #(.LEDS(LEDS), .BITS_PER_LED(BPL), .CH_BITS(CHB)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int gamma_ref(input int c);
`ifdef RGBLED_SCALER_GAMMA_EN
        return $rtoi(255.0 * ((real'(c) / 255.0) ** 2.2) + 0.5);
`else
        return c;
`endif
    endfunction

    // Each channel becomes floor(g(c) * (b + 1) / 256).
    function automatic logic [FW-1:0] model(input logic [FW-1:0] d, input logic [CHB-1:0] b);
        logic [FW-1:0] r;
        int c;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            c = gamma_ref(int'(d[k*CHB +: CHB]));
            r[k*CHB +: CHB] = CHB'((c * (int'(b) + 1)) / 256);
        end
        return r;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[FW-1:0];
    endfunction

    task automatic watch(input int cycles, output int npulse, output int first_at,
                         output logic [FW-1:0] d0, output logic [FW-1:0] d1, output logic busy_mid);
        npulse   = 0;
        first_at = -1;
        d0       = '0;
        d1       = '0;
        busy_mid = 1'b0;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk);
            #1;
            if (i == 10)
                busy_mid = bus.busy;
            if (bus.out_rdy) begin
                if (npulse == 0) begin
                    first_at = i;
                    d0 = bus.out_data;
                end else begin
                    d1 = bus.out_data;
                end
                npulse++;
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [FW-1:0] d, input logic [CHB-1:0] b,
                             output logic [FW-1:0] got);
        int np, fa;
        logic [FW-1:0] d1;
        logic bm;
        logic [FW-1:0] exp;
        exp = model(d, b);
        @(negedge clk);
        bus.in_data    = d;
        bus.brightness = b;
        bus.in_rdy     = 1'b1;
        watch(120, np, fa, got, d1, bm);
        frame_no++;
        $display("frame %0d %s: in=%h b=%h out=%h pulses=%0d at=%0d", frame_no, tag, d, b, got, np, fa);
        check_val({tag, "_pulses"}, FW'(np), FW'(1));
        check_val({tag, "_latency"}, FW'(fa), FW'(EXP_LAT));
        check_val({tag, "_data"}, got, exp);
        check_val({tag, "_busy_mid"}, FW'(bm), FW'(1));
        check_val({tag, "_busy_end"}, FW'(bus.busy), FW'(0));
        check_val({tag, "_hold"}, bus.out_data, exp);
        bus.in_rdy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [FW-1:0] got, a_d, b_d, d0, d1;
        logic [CHB-1:0] b1, b2;
        logic bm;
        int np, fa;

        errors   = 0;
        checks   = 0;
        frame_no = 0;
        nreset   = 1'b0;
        bus.in_data    = '0;
        bus.brightness = '0;
        bus.in_rdy     = 1'b0;

        // Held in reset with in_rdy toggling: everything stays at zero.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_rdy  = ~bus.in_rdy;
            bus.in_data = rand_frame();
            @(posedge clk);
            #1;
            check_val("rst_out_rdy", FW'(bus.out_rdy), FW'(0));
            check_val("rst_busy", FW'(bus.busy), FW'(0));
            check_val("rst_out_data", bus.out_data, '0);
        end
        @(negedge clk);
        bus.in_rdy = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (4) @(negedge clk);

        run_frame("full", 72'h123456_ABCDEF_FF0080, 8'hFF, got);
        check_val("full_passthru", got, 72'h123456_ABCDEF_FF0080);

        run_frame("half", 72'h000000_000000_0180FF, 8'h7F, got);
`ifndef RGBLED_SCALER_GAMMA_EN
        check_val("half_const", got, 72'h000000_000000_00407F);
`endif
        run_frame("zero", 72'hFFFFFF_FFFFFF_FFFFFF, 8'h00, got);
        check_val("zero_const", got, '0);

`ifdef RGBLED_SCALER_GAMMA_EN
        run_frame("gamma", 72'h000000_000000_000080, 8'hFF, got);
        check_val("gamma_0x80", FW'(got[7:0]), FW'(8'h38));
`endif

        for (int n = 0; n < 8; n++)
            run_frame("rand", rand_frame(), 8'($urandom), got);

        // Three edges in one busy period, data and brightness changed before the last.
        a_d = rand_frame();
        b_d = rand_frame();
        b1  = 8'($urandom);
        b2  = 8'($urandom);
        @(negedge clk);
        bus.in_data    = a_d;
        bus.brightness = b1;
        bus.in_rdy     = 1'b1;
        fork
            watch(260, np, fa, d0, d1, bm);
            begin
                repeat (10) @(negedge clk);
                bus.in_rdy = 1'b0;
                repeat (4) @(negedge clk);
                bus.in_rdy = 1'b1;
                repeat (4) @(negedge clk);
                bus.in_rdy = 1'b0;
                repeat (4) @(negedge clk);
                bus.in_data    = b_d;
                bus.brightness = b2;
                bus.in_rdy     = 1'b1;
            end
        join
        frame_no++;
        $display("frame %0d pending: pulses=%0d first=%h second=%h", frame_no, np, d0, d1);
        check_val("pend_pulses", FW'(np), FW'(2));
        check_val("pend_latency", FW'(fa), FW'(EXP_LAT));
        check_val("pend_first", d0, model(a_d, b1));
        check_val("pend_second", d1, model(b_d, b2));
        check_val("pend_busy_end", FW'(bus.busy), FW'(0));
        bus.in_rdy = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-frame aborts without a pulse.
        @(negedge clk);
        bus.in_data    = rand_frame();
        bus.brightness = 8'hFF;
        bus.in_rdy     = 1'b1;
        fork
            watch(120, np, fa, d0, d1, bm);
            begin
                repeat (32) @(posedge clk);
                #2 nreset = 1'b0;
                repeat (2) @(negedge clk);
                bus.in_rdy = 1'b0;
                repeat (2) @(negedge clk);
                nreset = 1'b1;
            end
        join
        frame_no++;
        $display("frame %0d abort: pulses=%0d out=%h", frame_no, np, bus.out_data);
        check_val("abort_pulses", FW'(np), FW'(0));
        check_val("abort_out_data", bus.out_data, '0);
        check_val("abort_busy", FW'(bus.busy), FW'(0));

        run_frame("after_rst", rand_frame(), 8'($urandom), got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
